// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM between NREQ engines,
// with locked bursts, frame-start fairness reset and a tagged read-return path.
module sprite_rom_arbiter #(
   parameter int NREQ      = 4,
   parameter int AW        = 17,
   parameter int DW        = 8,
   parameter int ROM_LAT   = 1,
   parameter int MAX_BURST = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_frame_start,
   input  logic [NREQ-1:0]   i_req,
   input  logic [NREQ-1:0]   i_lock,
   input  logic [NREQ*AW-1:0] i_addr,
   output logic [NREQ-1:0]   o_gnt,
   output logic [AW-1:0]     o_rom_addr,
   output logic              o_rom_en,
   input  logic [DW-1:0]     i_rom_data,
   output logic [NREQ-1:0]   o_rd_valid,
   output logic [DW-1:0]     o_rd_data
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAX_BURST);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

   typedef enum logic {ST_ARB, ST_BURST} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [NREQ-1:0] arb_gnt;
   logic [PW-1:0]   arb_idx;
   logic [PW-1:0]   scan_idx;
   logic            arb_found;
   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   sel_idx;

   logic            rom_en_q;
   logic [AW-1:0]   rom_addr_q;
   logic [NREQ-1:0] tag_q [ROM_LAT+1];
   logic [NREQ-1:0] rd_valid_q;
   logic [DW-1:0]   rd_data_q;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] k);
      return (int'(k) == NREQ - 1) ? '0 : k + 1'b1;
   endfunction

   // Scan starting at ptr; the first requester found wins.
   always_comb begin
      arb_gnt   = '0;
      arb_idx   = '0;
      arb_found = 1'b0;
      scan_idx  = '0;
      for (int i = 0; i < NREQ; i++) begin
         scan_idx = PW'((int'(ptr_q) + i) % NREQ);
         if (!arb_found && i_req[scan_idx]) begin
            arb_found = 1'b1;
            arb_idx   = scan_idx;
         end
      end
      arb_gnt[arb_idx] = arb_found;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      gnt     = '0;
      sel_idx = arb_idx;
      if (i_frame_start) begin
         state_d = ST_ARB;
         ptr_d   = '0;
         cnt_d   = '0;
      end else if (state_q == ST_ARB) begin
         gnt = arb_gnt;
         if (arb_found) begin
            if (i_lock[arb_idx]) begin
               state_d = ST_BURST;
               owner_d = arb_idx;
               cnt_d   = CW'(1);
            end else begin
               ptr_d = wrap_inc(arb_idx);
            end
         end
      end else begin
         sel_idx = owner_q;
         if (i_req[owner_q]) begin
            gnt[owner_q] = 1'b1;
            if (!i_lock[owner_q] || cnt_q == CNT_LAST) begin
               state_d = ST_ARB;
               ptr_d   = wrap_inc(owner_q);
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            // Owner let go: the burst ends with an idle cycle.
            state_d = ST_ARB;
            ptr_d   = wrap_inc(owner_q);
            cnt_d   = '0;
         end
      end
      if (!i_rst) gnt = '0;
   end

   assign o_gnt = gnt;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_ARB;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   // Tags ride alongside the ROM access so returned data keeps its owner.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rom_en_q   <= 1'b0;
         rom_addr_q <= '0;
         for (int s = 0; s <= ROM_LAT; s++) tag_q[s] <= '0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         rom_en_q <= |gnt;
         if (|gnt) rom_addr_q <= i_addr[int'(sel_idx)*AW +: AW];
         tag_q[0] <= gnt;
         for (int s = 1; s <= ROM_LAT; s++) tag_q[s] <= tag_q[s-1];
         rd_valid_q <= tag_q[ROM_LAT];
         if (|tag_q[ROM_LAT]) rd_data_q <= i_rom_data;
      end
   end

   assign o_rom_en   = rom_en_q;
   assign o_rom_addr = rom_addr_q;
   assign o_rd_valid = rd_valid_q;
   assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vectors, a per-cycle behavioural model
// with a ROM model, plus literal expectations for each scenario.
module tb_sprite_rom_arbiter;

   localparam int NREQ      = 4;
   localparam int AW        = 17;
   localparam int DW        = 8;
   localparam int ROM_LAT   = 1;
   localparam int MAX_BURST = 8;

   localparam logic [3:0] T1 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                     4'b0001, 4'b0010, 4'b0100, 4'b1000};

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b0;
   logic              i_frame_start = 1'b0;
   logic [NREQ-1:0]   i_req = '0;
   logic [NREQ-1:0]   i_lock = '0;
   logic [NREQ*AW-1:0] i_addr = '0;
   logic [NREQ-1:0]   o_gnt;
   logic [AW-1:0]     o_rom_addr;
   logic              o_rom_en;
   logic [DW-1:0]     i_rom_data;
   logic [NREQ-1:0]   o_rd_valid;
   logic [DW-1:0]     o_rd_data;

   int n_cmp  = 0;
   int n_fail = 0;
   int step   = 0;

   sprite_rom_arbiter #(
      .NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT), .MAX_BURST(MAX_BURST)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start),
      .i_req(i_req), .i_lock(i_lock), .i_addr(i_addr),
      .o_gnt(o_gnt), .o_rom_addr(o_rom_addr), .o_rom_en(o_rom_en),
      .i_rom_data(i_rom_data), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h5A;
   endfunction

   // Synchronous ROM, one cycle of latency.
   logic [DW-1:0] rom_q;
   always @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) rom_q <= '0;
      else if (o_rom_en) rom_q <= rom_f(o_rom_addr);
   end
   assign i_rom_data = rom_q;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: grant history hg[n] is the grant made n cycles ago.
   bit              m_burst;
   int              m_ptr, m_owner, m_beats;
   logic [NREQ-1:0] hg [1:3];
   logic [AW-1:0]   ha [1:3];
   logic [AW-1:0]   e_addr;
   logic [DW-1:0]   e_data;

   always @(negedge i_clk) begin : model
      logic [NREQ-1:0] g;
      int k;
      if (!i_rst) begin
         chk("rst_gnt", 32'(o_gnt), 32'd0);
         chk("rst_rom_en", 32'(o_rom_en), 32'd0);
         chk("rst_rom_addr", 32'(o_rom_addr), 32'd0);
         chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
         chk("rst_rd_data", 32'(o_rd_data), 32'd0);
         m_burst = 1'b0; m_ptr = 0; m_owner = 0; m_beats = 0;
         for (int n = 1; n <= 3; n++) begin hg[n] = '0; ha[n] = '0; end
         e_addr = '0; e_data = '0;
      end else begin
         if (hg[1] != 0) e_addr = ha[1];
         if (hg[3] != 0) e_data = rom_f(ha[3]);
         chk("m_rom_en", 32'(o_rom_en), 32'(hg[1] != 0));
         chk("m_rom_addr", 32'(o_rom_addr), 32'(e_addr));
         chk("m_rd_valid", 32'(o_rd_valid), 32'(hg[3]));
         chk("m_rd_data", 32'(o_rd_data), 32'(e_data));
         g = '0;
         k = -1;
         if (i_frame_start) k = -1;
         else if (m_burst) begin
            if (i_req[m_owner]) k = m_owner;
         end else begin
            for (int i = 0; i < NREQ; i++)
               if (k < 0 && i_req[(m_ptr + i) % NREQ]) k = (m_ptr + i) % NREQ;
         end
         if (k >= 0) g[k] = 1'b1;
         chk("m_gnt", 32'(o_gnt), 32'(g));
         if (i_frame_start) begin
            m_burst = 1'b0; m_ptr = 0;
         end else if (m_burst) begin
            if (k >= 0) begin
               m_beats++;
               if (!i_lock[m_owner] || m_beats == MAX_BURST) begin
                  m_burst = 1'b0; m_ptr = (m_owner + 1) % NREQ;
               end
            end else begin
               m_burst = 1'b0; m_ptr = (m_owner + 1) % NREQ;
            end
         end else if (k >= 0) begin
            if (i_lock[k]) begin
               m_burst = 1'b1; m_owner = k; m_beats = 1;
            end else m_ptr = (k + 1) % NREQ;
         end
         hg[3] = hg[2]; ha[3] = ha[2];
         hg[2] = hg[1]; ha[2] = ha[1];
         hg[1] = g;
         ha[1] = (k >= 0) ? i_addr[k*AW +: AW] : '0;
      end
   end

   task automatic set_addrs();
      step++;
      for (int k = 0; k < NREQ; k++) i_addr[k*AW +: AW] = AW'((k << 13) + step * 7 + k);
   endtask

   task automatic cyc(input logic [3:0] req, input logic [3:0] lock, input logic fs);
      @(posedge i_clk);
      #1;
      set_addrs();
      i_req = req;
      i_lock = lock;
      i_frame_start = fs;
      @(negedge i_clk);
   endtask

   initial begin
      i_rst = 1'b0;
      i_req = 4'hF;
      repeat (2) @(negedge i_clk);
      chk("reset_gnt_masked", 32'(o_gnt), 32'd0);
      chk("reset_rom_en", 32'(o_rom_en), 32'd0);
      chk("reset_rd_valid", 32'(o_rd_valid), 32'd0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      i_req = '0;
      @(negedge i_clk);

      // All four requesting, no locks: plain rotation.
      for (int i = 0; i < 8; i++) begin
         cyc(4'hF, 4'h0, 1'b0);
         chk("rr_gnt", 32'(o_gnt), 32'(T1[i]));
         if (i >= 3) chk("rr_rd_valid", 32'(o_rd_valid), 32'(T1[i-3]));
      end
      repeat (4) cyc(4'h0, 4'h0, 1'b0);

      // Locked burst by requester 2; next winner is 3 if present, else 0.
      for (int v = 0; v < 2; v++) begin
         logic [3:0] req_all;
         req_all = (v == 0) ? 4'b1111 : 4'b0111;
         cyc(req_all, 4'h0, 1'b1);
         chk("fs_gnt_forced", 32'(o_gnt), 32'd0);
         cyc(4'b0010, 4'h0, 1'b0);
         chk("pre_burst_gnt", 32'(o_gnt), 32'b0010);
         for (int b = 0; b < MAX_BURST; b++) begin
            cyc(req_all, 4'b0100, 1'b0);
            chk("burst_gnt", 32'(o_gnt), 32'b0100);
         end
         cyc(req_all, 4'b0100, 1'b0);
         chk("post_burst_gnt", 32'(o_gnt), (v == 0) ? 32'b1000 : 32'b0001);
         repeat (3) cyc(4'h0, 4'h0, 1'b0);
      end

      // Requester 1 drops its request mid-burst.
      cyc(4'h0, 4'h0, 1'b1);
      cyc(4'b0001, 4'h0, 1'b0);
      for (int b = 0; b < 3; b++) begin
         cyc(4'b0110, 4'b0010, 1'b0);
         chk("drop_burst_gnt", 32'(o_gnt), 32'b0010);
      end
      cyc(4'b0100, 4'h0, 1'b0);
      chk("drop_idle_gnt", 32'(o_gnt), 32'd0);
      cyc(4'b0100, 4'h0, 1'b0);
      chk("drop_next_gnt", 32'(o_gnt), 32'b0100);
      chk("drop_idle_rom_en", 32'(o_rom_en), 32'd0);
      repeat (3) cyc(4'h0, 4'h0, 1'b0);

      // Frame start in the middle of requester 3's burst.
      cyc(4'h0, 4'h0, 1'b1);
      cyc(4'b0100, 4'h0, 1'b0);
      cyc(4'b1111, 4'b1000, 1'b0);
      chk("fsb_gnt0", 32'(o_gnt), 32'b1000);
      cyc(4'b1111, 4'b1000, 1'b0);
      chk("fsb_gnt1", 32'(o_gnt), 32'b1000);
      cyc(4'b1111, 4'b1000, 1'b1);
      chk("fsb_gnt_forced", 32'(o_gnt), 32'd0);
      cyc(4'b1111, 4'b1000, 1'b0);
      chk("fsb_gnt_after", 32'(o_gnt), 32'b0001);
      chk("fsb_inflight0", 32'(o_rd_valid), 32'b1000);
      cyc(4'h0, 4'h0, 1'b0);
      chk("fsb_inflight1", 32'(o_rd_valid), 32'b1000);
      repeat (3) cyc(4'h0, 4'h0, 1'b0);

      // Asynchronous reset with reads in flight.
      repeat (3) cyc(4'hF, 4'h0, 1'b0);
      @(posedge i_clk);
      #1;
      chk("pre_rst_rom_en", 32'(o_rom_en), 32'd1);
      i_rst = 1'b0;
      #1;
      chk("arst_gnt", 32'(o_gnt), 32'd0);
      chk("arst_rom_en", 32'(o_rom_en), 32'd0);
      chk("arst_rom_addr", 32'(o_rom_addr), 32'd0);
      chk("arst_rd_valid", 32'(o_rd_valid), 32'd0);
      chk("arst_rd_data", 32'(o_rd_data), 32'd0);
      @(negedge i_clk);
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      set_addrs();
      i_req = 4'b1110;
      i_lock = 4'h0;
      i_frame_start = 1'b0;
      @(negedge i_clk);
      chk("post_rst_gnt", 32'(o_gnt), 32'b0010);
      cyc(4'h0, 4'h0, 1'b0);
      chk("post_rst_rdv1", 32'(o_rd_valid), 32'd0);
      cyc(4'h0, 4'h0, 1'b0);
      chk("post_rst_rdv2", 32'(o_rd_valid), 32'd0);
      cyc(4'h0, 4'h0, 1'b0);
      chk("post_rst_rdv3", 32'(o_rd_valid), 32'b0010);
      cyc(4'h0, 4'h0, 1'b0);
      chk("post_rst_rdv4", 32'(o_rd_valid), 32'd0);

      // Requester 3 alone streaming every cycle.
      for (int i = 0; i < 10; i++) begin
         cyc(4'b1000, 4'h0, 1'b0);
         chk("solo_gnt", 32'(o_gnt), 32'b1000);
         if (i >= 1) chk("solo_rom_en", 32'(o_rom_en), 32'd1);
         if (i >= 3) chk("solo_rd_valid", 32'(o_rd_valid), 32'b1000);
      end
      repeat (4) cyc(4'h0, 4'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite ROM (8-bit pixel data, 17-bit address) between several sprite engines (title screen, falling tiles, score digits, game-over banner) inside the VGA pixel pipeline. Each engine raises a request with an address; the arbiter grants one per cycle, round-robin, and issues the address to the ROM. It returns the ROM data tagged to the winning requester after the fixed ROM latency. Short locked bursts let one engine fetch contiguous sprite-row pixels. The per-frame pulse from the VGA timing block resets arbitration fairness.

## Interface
- NREQ, 4: number of requesters (2..8)
- AW, 17: ROM address width
- DW, 8: ROM data width
- ROM_LAT, 1: ROM read latency in cycles, from the o_rom_en cycle to i_rom_data valid (1..3)
- MAX_BURST, 8: maximum beats per locked burst (2..16)

- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_frame_start  in  1  one-cycle pulse at start of frame
- i_req  in  NREQ  request per requester
- i_lock  in  NREQ  request burst continuation, qualified by i_req
- i_addr  in  NREQ*AW  requester k address in bits [k*AW +: AW]
- o_gnt  out  NREQ  one-hot accept, combinational; beat accepted on edge where i_req[k] & o_gnt[k]
- o_rom_addr  out  AW  registered ROM address
- o_rom_en  out  1  registered ROM read strobe
- i_rom_data  in  DW  ROM data, valid ROM_LAT cycles after o_rom_en
- o_rd_valid  out  NREQ  one-hot, registered; marks o_rd_data owner
- o_rd_data  out  DW  registered returned data

## Operation
- State: ARB or BURST; ptr (round-robin start, 0..NREQ-1); owner; beat count cnt.
- ARB: o_gnt = lowest-index-from-ptr requester with i_req set, scanning ptr, ptr+1, ... mod NREQ. At most one bit set.
- Beat accepted to k in ARB: if i_lock[k]=0, ptr <= (k+1) mod NREQ, stay ARB. If i_lock[k]=1, state <= BURST, owner <= k, cnt <= 1; ptr unchanged.
- BURST: o_gnt[owner] = i_req[owner]; all others 0.
  - Accepted beat with i_lock[owner]=0, or with cnt = MAX_BURST-1: state <= ARB, ptr <= owner+1 mod NREQ. Otherwise cnt <= cnt+1.
  - i_req[owner]=0: no grant that cycle; state <= ARB, ptr <= owner+1.
- i_frame_start=1: o_gnt forced 0 that cycle; state <= ARB, ptr <= 0, cnt <= 0. Overrides all above. In-flight reads still return.
- Accepted beat: o_rom_addr <= i_addr[k], o_rom_en <= 1 next cycle; otherwise o_rom_en <= 0, o_rom_addr holds.
- Tag pipeline: one-hot grant shifted ROM_LAT+1 stages. o_rd_valid <= tag and o_rd_data <= i_rom_data when tag non-zero; o_rd_data holds otherwise.
- Reset values: state ARB, ptr 0, cnt 0, owner 0, o_rom_en 0, o_rom_addr 0, tag pipe 0, o_rd_valid 0, o_rd_data 0. o_gnt is 0 while i_rst is low.

## Timing
- Accept at edge t. o_rom_en/o_rom_addr valid during cycle t+1. i_rom_data valid t+1+ROM_LAT. o_rd_valid/o_rd_data valid t+2+ROM_LAT (ROM_LAT=1: 3 cycles after acceptance edge).
- Throughput one beat per cycle sustained; back-to-back beats from different requesters have no bubble.
- Return order equals grant order; no reordering.
- Worst-case wait for any requester holding i_req: (NREQ-1)*MAX_BURST cycles, excluding frame-start cycles.
- Reset asserted mid-burst or with reads in flight: everything clears immediately; pending return data is discarded (no o_rd_valid after reset).

## Test plan
- Reset then i_req=4'b1111, i_lock=0 for 8 cycles -> o_gnt sequence 0001,0010,0100,1000,0001,...; o_rd_valid mirrors it 3 cycles later (ROM_LAT=1); o_rd_data matches ROM model at each address.
- Requester 2 holds i_req with i_lock=1, requesters 0,1 also requesting -> requester 2 gets exactly 8 consecutive grants, then requester 3 if requesting, else 0; ptr=3 after burst.
- Burst by requester 1 with i_req[1] dropped after 3 beats -> 3 grants, one idle cycle (o_gnt=0, o_rom_en=0 one cycle later), then requester 2 granted.
- i_frame_start pulsed during burst by requester 3 with i_req=1111 -> o_gnt=0 that cycle; next cycle grant to requester 0; the 2 in-flight reads still return with o_rd_valid=1000.
- i_rst pulsed low while o_rom_en=1 -> all outputs 0 asynchronously; no o_rd_valid after release; first grant after release goes to lowest-index requester.
- Single requester 3 alone, i_lock=0, continuous -> grant every cycle, o_rom_en high continuously, data returned in order with no gaps.
